// File: rtl/logic_pipe.sv
`timescale 1ns/1ps
// logic_pipe
// Two-stage, back-pressurable bitwise logic unit. Operands enter with a
// valid/ready handshake, are registered in stage 1 together with the
// operation select, and the result (plus zero flag and population count) is
// registered in stage 2 and offered to the consumer with valid/ready.
// A running counter tracks completed output transfers.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   unit accepts a beat this cycle (combinational on out_ready)
//   op         operation select: 000 AND, 001 OR, 010 NAND, 011 NOR,
//              100 XOR, 101 XNOR, 110 NOT A, 111 PASS A
//   a, b       W-bit operands (b ignored for NOT A / PASS A)
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   y          W-bit result
//   zero       y == 0 (meaningful while out_valid)
//   ones       number of 1 bits in y (meaningful while out_valid)
//   count      completed output transfers, modulo 2^CW
module logic_pipe #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             y,
    output logic                     zero,
    output logic [$clog2(W+1)-1:0]   ones,
    output logic [CW-1:0]            count
);

    localparam int OW = $clog2(W+1);

    logic           vld_p1;
    logic [2:0]     op_p1;
    logic [W-1:0]   a_p1;
    logic [W-1:0]   b_p1;

    logic           vld_p2;
    logic [W-1:0]   y_p2;
    logic           zero_p2;
    logic [OW-1:0]  ones_p2;

    logic           adv1;
    logic           adv2;
    logic [W-1:0]   y_c;

    function automatic logic [W-1:0] logic_op(input logic [2:0] sel,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] z);
        logic [W-1:0] r;
        r = '0;
        case (sel)
            3'b000:  r = x & z;
            3'b001:  r = x | z;
            3'b010:  r = ~(x & z);
            3'b011:  r = ~(x | z);
            3'b100:  r = x ^ z;
            3'b101:  r = ~(x ^ z);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [OW-1:0] pop_count(input logic [W-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    // A stage may load when it is empty or when the stage after it is
    // emptying on this edge; in_ready therefore sees out_ready directly.
    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1 && rst_n;

    assign y_c = logic_op(op_p1, a_p1, b_p1);

    // ---- stage 1: capture operands and select ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            op_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else if (adv1) begin
            vld_p1 <= in_valid && in_ready;
            op_p1  <= op;
            a_p1   <= a;
            b_p1   <= b;
        end
    end

    // ---- stage 2: capture result and its flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            y_p2    <= '0;
            zero_p2 <= 1'b0;
            ones_p2 <= '0;
        end else if (adv2) begin
            vld_p2  <= vld_p1;
            y_p2    <= y_c;
            zero_p2 <= (y_c == '0);
            ones_p2 <= pop_count(y_c);
        end
    end

    // ---- output side: completed-transfer counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (vld_p2 && out_ready) begin
            count <= count + CW'(1);
        end
    end

    assign out_valid = vld_p2;
    assign y         = y_p2;
    assign zero      = zero_p2;
    assign ones      = ones_p2;

endmodule
